// File: rtl/playfield_renderer_pkg.sv
// playfield_renderer_pkg: shared types and beam/board geometry for the playfield renderer
package playfield_renderer_pkg;

    typedef logic [7:0] address_t;
    typedef logic [2:0] colour_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_START,
        F_STREAM
    } fetch_state_t;

    localparam logic [7:0] H_LAST    = 8'd129;
    localparam logic [9:0] V_LAST    = 10'd665;
    localparam logic [7:0] H_VISIBLE = 8'd100;
    localparam logic [9:0] V_VISIBLE = 10'd600;

    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;

endpackage

// File: rtl/playfield_renderer_row_tracker.sv
// playfield_row_tracker: tracks which board row and which line inside that row the beam is on
module playfield_row_tracker
    import playfield_renderer_pkg::*;
#(
    parameter int Y0     = 60,
    parameter int CELL_H = 24,
    parameter int SUB_W  = $clog2(CELL_H)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       pixel,
    input  logic [9:0]       scanline,
    output logic             active,
    output logic [4:0]       row,
    output logic [SUB_W-1:0] sub
);

    localparam logic [9:0]       Y_TOP    = 10'(Y0 - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_H - 1);
    localparam logic [4:0]       ROW_LAST = 5'(BOARD_ROWS - 1);

    logic             active_q, active_d;
    logic [4:0]       row_q, row_d;
    logic [SUB_W-1:0] sub_q, sub_d;

    // Advance the row/sub counters once per line, on its last pixel; rearm on the line above the board
    always_comb begin
        active_d = active_q;
        row_d    = row_q;
        sub_d    = sub_q;
        if (pixel == H_LAST) begin
            if (scanline == Y_TOP) begin
                active_d = 1'b1;
                row_d    = '0;
                sub_d    = '0;
            end else if (active_q) begin
                if (sub_q == SUB_LAST) begin
                    sub_d = '0;
                    row_d = row_q + 5'd1;
                    if (row_q == ROW_LAST) active_d = 1'b0;
                end else begin
                    sub_d = sub_q + SUB_W'(1);
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            row_q    <= '0;
            sub_q    <= '0;
        end else begin
            active_q <= active_d;
            row_q    <= row_d;
            sub_q    <= sub_d;
        end
    end

    assign active = active_q;
    assign row    = row_q;
    assign sub    = sub_q;

endmodule

// File: rtl/playfield_renderer.sv
// playfield_renderer: streams one board row per scanline from cell memory and colours the beam
module playfield_renderer
    import playfield_renderer_pkg::*;
#(
    parameter int      X0           = 30,
    parameter int      Y0           = 60,
    parameter int      CELL_W       = 4,
    parameter int      CELL_H       = 24,
    parameter int      ROW_BASE     = 0,
    parameter colour_t BORDER_COLOR = 3'b111,
    parameter bit      GRID         = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] pixel,
    input  logic [9:0] scanline,
    input  colour_t    mem_data_in,
    output logic       mem_start,
    output logic       mem_cont,
    output logic       mem_write_enable,
    output address_t   mem_addr,
    output logic       mem_owned,
    output logic       r,
    output logic       g,
    output logic       b
);

    localparam int         SUB_W    = $clog2(CELL_H);
    localparam logic [7:0] PX_TRIG  = 8'(X0 - 3);
    localparam logic [7:0] PX_BL    = 8'(X0 - 1);
    localparam logic [7:0] PX_L     = 8'(X0);
    localparam logic [7:0] PX_R     = 8'(X0 + BOARD_COLS * CELL_W);
    localparam logic [9:0] Y_TOP    = 10'(Y0 - 1);
    localparam logic [9:0] Y_BOT    = 10'(Y0 + BOARD_ROWS * CELL_H);
    localparam logic [3:0] COL_LAST = 4'(BOARD_COLS - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_H - 1);

    logic             active;
    logic [4:0]       row;
    logic [SUB_W-1:0] sub;

    fetch_state_t state_q, state_d;
    address_t     addr_q, addr_d;
    logic [3:0]   k_q, k_d;
    colour_t      cell_q, cell_d;
    logic [7:0]   cap_px, rel;
    logic         cap, in_board, grid_blank, border;
    colour_t      rgb;

    playfield_row_tracker #(
        .Y0     (Y0),
        .CELL_H (CELL_H),
        .SUB_W  (SUB_W)
    ) u_row_tracker (
        .clk      (clk),
        .reset_n  (reset_n),
        .pixel    (pixel),
        .scanline (scanline),
        .active   (active),
        .row      (row),
        .sub      (sub)
    );

    // Fetch FSM: open the burst two pixels ahead of the board, capture one cell per CELL_W pixels
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        k_d       = k_q;
        cell_d    = cell_q;
        cap_px    = 8'(X0 - 1 + int'(k_q) * CELL_W);
        cap       = (state_q == F_STREAM) && (pixel == cap_px);
        mem_start = (state_q == F_START);
        mem_owned = (state_q != F_IDLE);
        mem_cont  = cap && (k_q != COL_LAST);
        if (pixel == H_LAST) begin
            state_d = F_IDLE;
        end else begin
            case (state_q)
                F_IDLE: begin
                    if (active && pixel == PX_TRIG) begin
                        state_d = F_START;
                        addr_d  = address_t'(ROW_BASE) + address_t'(row);
                        k_d     = '0;
                    end
                end
                F_START: state_d = F_STREAM;
                F_STREAM: begin
                    if (cap) begin
                        cell_d = mem_data_in;
                        k_d    = k_q + 4'd1;
                        if (k_q == COL_LAST) state_d = F_IDLE;
                    end
                end
                default: state_d = F_IDLE;
            endcase
        end
    end

    // Fetch state, latched row address and the current cell colour
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= F_IDLE;
            addr_q  <= '0;
            k_q     <= '0;
            cell_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            cell_q  <= cell_d;
        end
    end

    // Colour mux: the frame is position-only and wins over cell data at the shared pixel
    always_comb begin
        rel        = pixel - PX_L;
        in_board   = active && (pixel >= PX_L) && (pixel < PX_R);
        grid_blank = GRID && ((rel % 8'(CELL_W) == 8'(CELL_W - 1)) || (sub == SUB_LAST));
        border     = (scanline >= Y_TOP) && (scanline <= Y_BOT) &&
                     ((pixel == PX_BL) || (pixel == PX_R) ||
                      (((scanline == Y_TOP) || (scanline == Y_BOT)) && (pixel >= PX_BL) && (pixel <= PX_R)));
        rgb        = border ? BORDER_COLOR : (in_board && !grid_blank) ? cell_q : 3'b000;
    end

    assign mem_addr         = addr_q;
    assign mem_write_enable = 1'b0;
    assign {r, g, b}        = rgb;

endmodule

// File: tb/tb_playfield_renderer.sv
// tb_playfield_renderer: random board contents checked against a positional model of the playfield
module tb_playfield_renderer;
    import playfield_renderer_pkg::*;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] pixel    = '0;
    logic [9:0] scanline = '0;

    colour_t  mem_data_in;
    logic     mem_start, mem_cont, mem_write_enable, mem_owned, r, g, b;
    address_t mem_addr;

    colour_t  ng_data = 3'b011;
    logic     ng_start, ng_cont, ng_we, ng_owned, ng_r, ng_g, ng_b;
    address_t ng_addr;

    colour_t  board [0:199];
    address_t bus_addr = '0;
    int       bus_idx  = 0;

    bit armed  = 1'b0;
    int n      = 0;
    bit do_rst = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    playfield_renderer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pixel            (pixel),
        .scanline         (scanline),
        .mem_data_in      (mem_data_in),
        .mem_start        (mem_start),
        .mem_cont         (mem_cont),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_owned        (mem_owned),
        .r                (r),
        .g                (g),
        .b                (b)
    );

    playfield_renderer #(.GRID(1'b0)) dut_ng (
        .clk              (clk),
        .reset_n          (reset_n),
        .pixel            (pixel),
        .scanline         (scanline),
        .mem_data_in      (ng_data),
        .mem_start        (ng_start),
        .mem_cont         (ng_cont),
        .mem_write_enable (ng_we),
        .mem_addr         (ng_addr),
        .mem_owned        (ng_owned),
        .r                (ng_r),
        .g                (ng_g),
        .b                (ng_b)
    );

    // Cell memory: start latches the row, each cont steps to the next cell
    always @(posedge clk) begin
        if (mem_start) begin
            bus_addr <= mem_addr;
            bus_idx  <= 0;
        end else if (mem_cont) begin
            bus_idx <= bus_idx + 1;
        end
    end

    always_comb mem_data_in = (bus_addr < 20 && bus_idx < 10) ? board[int'(bus_addr) * 10 + bus_idx] : 3'b000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (pixel %0d scanline %0d)", tag, got, exp, pixel, scanline);
        end
    endtask

    function automatic logic [2:0] ref_rgb(int p, int s, bit rows, int line, bit grid, bit ng);
        if (s >= 59 && s <= 540 && (p == 29 || p == 70 || ((s == 59 || s == 540) && p >= 29 && p <= 70)))
            return 3'b111;
        if (!rows || p < 30 || p >= 70) return 3'b000;
        if (grid && ((p - 30) % 4 == 3 || line % 24 == 23)) return 3'b000;
        return ng ? 3'b011 : board[(line / 24) * 10 + (p - 30) / 4];
    endfunction

    task automatic step(input int p, input int s);
        bit rows;
        pixel    = 8'(p);
        scanline = 10'(s);
        if (!reset_n) armed = 1'b0;
        @(negedge clk);
        rows = armed && n < 480;
        check("rgb",        {r, g, b},       ref_rgb(p, s, rows, n, 1'b1, 1'b0));
        check("rgb_nogrid", {ng_r, ng_g, ng_b}, ref_rgb(p, s, rows, n, 1'b0, 1'b1));
        check("mem_start",  mem_start,  rows && p == 28);
        check("mem_cont",   mem_cont,   rows && p >= 29 && p <= 61 && (p - 29) % 4 == 0);
        check("mem_owned",  mem_owned,  rows && p >= 28 && p <= 65);
        check("mem_we",     mem_write_enable, 0);
        check("ng_start",   ng_start,   rows && p == 28);
        check("ng_cont",    ng_cont,    rows && p >= 29 && p <= 61 && (p - 29) % 4 == 0);
        check("ng_owned",   ng_owned,   rows && p >= 28 && p <= 65);
        check("ng_we",      ng_we,      0);
        if (rows && p == 28) begin
            check("mem_addr", mem_addr, n / 24);
            check("ng_addr",  ng_addr,  n / 24);
        end
        if (!reset_n) check("rst_addr", mem_addr, 0);
        if (reset_n && p == 129) begin
            if (s == 59) begin
                armed = 1'b1;
                n     = 0;
            end else if (armed) begin
                n++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input int s, input bit full);
        int a = full ? 0 : int'($urandom_range(10, 26));
        int e = full ? 128 : int'($urandom_range(71, 80));
        for (int p = a; p <= e; p++) begin
            if (do_rst && s == 300 && p == 50) reset_n = 1'b0;
            if (do_rst && s == 300 && p == 53) begin
                reset_n = 1'b1;
                do_rst  = 1'b0;
            end
            step(p, s);
        end
        step(129, s);
    endtask

    initial begin
        for (int i = 0; i < 200; i++) board[i] = colour_t'($urandom_range(0, 7));
        board[0] = 3'b100;
        for (int i = 1; i < 10; i++) board[i] = 3'b000;
        for (int i = 0; i < 3; i++) step(0, 0);
        reset_n = 1'b1;
        for (int s = 58; s <= 541; s++) run_line(s, s == 60 || s == 540 || $urandom_range(0, 15) == 0);
        run_line(665, 1'b0);
        run_line(0, 1'b0);
        run_line(1, 1'b0);
        for (int i = 0; i < 200; i++) board[i] = colour_t'($urandom_range(0, 7));
        do_rst = 1'b1;
        for (int s = 58; s <= 303; s++) run_line(s, 1'b0);
        for (int s = 58; s <= 100; s++) run_line(s, s == 60);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
